data_sram_responder: RTL and testbench

- Synchronous, wait-state-capable responder for the CPU data-memory interface (addr / we_n / write data / read data).
- Replaces the zero-latency combinational data SRAM behind the pipelined CPU, so the core's stall path can be exercised against a memory that answers after a programmable number of cycles.
- Adds a valid/ready request handshake, a one-cycle response pulse and an out-of-range error flag.
- A combinational debug read port lets benches dump result words without disturbing the request path.

---
 rtl/data_sram_pkg.sv | 15 +
 rtl/sram_array.sv | 35 +++
 rtl/data_sram_responder.sv | 150 +++++++++++++++
 tb/tb_data_sram_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_pkg.sv
// Shared encodings for the data SRAM responder.
//   state_e  : responder FSM state encoding
//   WE_WRITE / WE_READ : decoded values of the active-low we_n strobe
package data_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic WE_WRITE = 1'b0;
  localparam logic WE_READ  = 1'b1;

endpackage

// File: rtl/sram_array.sv
// DEPTH x DATA_WIDTH storage for the data SRAM responder.
//   clk      : clock
//   idx      : shared word index for the write and read ports
//   wr_en    : write wr_data to mem[idx] at the rising edge
//   wr_data  : write data
//   rd_en    : capture mem[idx] into rd_data at the rising edge
//   rd_data  : registered read data, holds until the next rd_en
//   dbg_idx  : debug read index
//   dbg_data : combinational mem[dbg_idx]
// Contents are never cleared so preloaded images survive reset.
module sram_array #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [IDX_W-1:0]      idx,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [IDX_W-1:0]      dbg_idx,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wr_data;
    if (rd_en) rd_data <= mem[idx];
  end

  assign dbg_data = mem[dbg_idx];

endmodule

// File: rtl/data_sram_responder.sv
// Wait-state-capable data-memory responder with valid/ready request handshake.
//   clk, reset         : clock, synchronous active-high reset
//   req_valid/req_ready: request handshake; we_n/addr/wdata sampled on handshake
//   resp_valid         : one-cycle response pulse
//   rdata, resp_err    : read data or write echo, out-of-range flag; held until next access
//   dbg_addr/dbg_data  : combinational debug read, 0 when out of range
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a request (req_ready = 1)
// ST_WAIT | request captured, counting wait states down to the access
// ST_RESP | access done, resp_valid high for this one cycle
module data_sram_responder
  import data_sram_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  we_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  resp_err,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int                  IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
  localparam bit                  ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]          WAIT_INIT = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e                state;
  logic [3:0]            wait_cnt;
  logic                  cap_we_n;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rd_sel;

  logic                  handshake;
  logic                  acc_now;
  logic                  acc_we_n;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_in_range;
  logic                  dbg_in_range;
  logic [DATA_WIDTH-1:0] arr_rd_data;
  logic [DATA_WIDTH-1:0] arr_dbg_data;

  assign handshake = req_valid & req_ready;

  // With zero wait states the access happens on the handshake edge itself,
  // so the live request fields are used instead of the capture registers.
  assign acc_we_n  = (state == ST_IDLE) ? we_n  : cap_we_n;
  assign acc_addr  = (state == ST_IDLE) ? addr  : cap_addr;
  assign acc_wdata = (state == ST_IDLE) ? wdata : cap_wdata;

  assign acc_now = !reset &
                   (((state == ST_IDLE) & handshake & ZERO_WAIT) |
                    ((state == ST_WAIT) & (wait_cnt == 4'd0)));

  assign acc_in_range = ({1'b0, acc_addr} < DEPTH_L);
  assign dbg_in_range = ({1'b0, dbg_addr} < DEPTH_L);

  sram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk     (clk),
    .idx     (acc_addr[IDX_W-1:0]),
    .wr_en   (acc_now & (acc_we_n == WE_WRITE) & acc_in_range),
    .wr_data (acc_wdata),
    .rd_en   (acc_now & (acc_we_n == WE_READ) & acc_in_range),
    .rd_data (arr_rd_data),
    .dbg_idx (dbg_addr[IDX_W-1:0]),
    .dbg_data(arr_dbg_data)
  );

  // A good read returns the array's own read register; writes and errors
  // return rdata_q, so rdata is always a function of registered state.
  assign rdata    = rd_sel ? arr_rd_data : rdata_q;
  assign dbg_data = dbg_in_range ? arr_dbg_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      wait_cnt   <= 4'd0;
      rdata_q    <= '0;
      rd_sel     <= 1'b0;
      cap_we_n   <= WE_READ;
      cap_addr   <= '0;
      cap_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            cap_we_n  <= we_n;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            req_ready <= 1'b0;
            if (ZERO_WAIT) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase

      if (acc_now) begin
        resp_err <= !acc_in_range;
        rd_sel   <= (acc_we_n == WE_READ) & acc_in_range;
        rdata_q  <= ((acc_we_n == WE_WRITE) & acc_in_range) ? acc_wdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        we_n;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] dbg_addr;

  logic        rv2, ready2, resp_valid2, err2;
  logic [15:0] rdata2, dbg2;
  logic        rv0, ready0, resp_valid0, err0;
  logic [15:0] rdata0, dbg0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(rv2), .req_ready(ready2),
    .we_n(we_n), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid2), .rdata(rdata2), .resp_err(err2),
    .dbg_addr(dbg_addr), .dbg_data(dbg2)
  );

  data_sram_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(ready0),
    .we_n(we_n), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid0), .rdata(rdata0), .resp_err(err0),
    .dbg_addr(dbg_addr), .dbg_data(dbg0)
  );

  // Issues one request on the WAIT_CYCLES=2 instance and returns the cycle
  // (1 = cycle right after the handshake edge) in which resp_valid was seen.
  task automatic run_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] rd, output logic er);
    @(negedge clk);
    we_n = w; addr = a; wdata = d; rv2 = 1'b1;
    @(posedge clk);
    #1 rv2 = 1'b0;
    lat = -1; rd = 16'h0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid2) begin
        lat = i; rd = rdata2; er = err2;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; rv2 = 1'b0; rv0 = 1'b0;
    we_n = 1'b1; addr = '0; wdata = '0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready2 !== 1'b1 || resp_valid2 !== 1'b0 || rdata2 !== 16'h0 || err2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_w2: ready=%b resp=%b rdata=%h err=%b, need 1 0 0000 0",
               ready2, resp_valid2, rdata2, err2);
    end
    checks++;
    if (ready0 !== 1'b1 || resp_valid0 !== 1'b0 || rdata0 !== 16'h0 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_w0: ready=%b resp=%b rdata=%h err=%b, need 1 0 0000 0",
               ready0, resp_valid0, rdata0, err0);
    end
  endtask

  task automatic test_write_read;
    int lat; logic [15:0] rd; logic er;
    run_req(1'b0, 16'd100, 16'h00AB, lat, rd, er);
    checks++;
    if (lat !== 3 || rd !== 16'h00AB || er !== 1'b0) begin
      errors++;
      $display("FAIL wr100: lat=%0d rdata=%h err=%b, need 3 00ab 0", lat, rd, er);
    end
    run_req(1'b1, 16'd100, 16'h0000, lat, rd, er);
    checks++;
    if (lat !== 3 || rd !== 16'h00AB || er !== 1'b0) begin
      errors++;
      $display("FAIL rd100: lat=%0d rdata=%h err=%b, need 3 00ab 0", lat, rd, er);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (resp_valid2 !== 1'b0 || rdata2 !== 16'h00AB || ready2 !== 1'b1) begin
      errors++;
      $display("FAIL hold: resp=%b rdata=%h ready=%b, need 0 00ab 1", resp_valid2, rdata2, ready2);
    end
  endtask

  task automatic test_zero_wait;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      we_n = (k == 1); addr = 16'd5; wdata = (k == 0) ? 16'h1234 : 16'h0000; rv0 = 1'b1;
      checks++;
      if (ready0 !== 1'b1) begin
        errors++;
        $display("FAIL zw_ready_idle%0d: ready=%b, need 1", k, ready0);
      end
      @(posedge clk);
      #1 rv0 = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_valid0 !== 1'b1 || ready0 !== 1'b0 || rdata0 !== 16'h1234 || err0 !== 1'b0) begin
        errors++;
        $display("FAIL zw_resp%0d: resp=%b ready=%b rdata=%h err=%b, need 1 0 1234 0",
                 k, resp_valid0, ready0, rdata0, err0);
      end
      @(negedge clk);
      checks++;
      if (resp_valid0 !== 1'b0 || ready0 !== 1'b1) begin
        errors++;
        $display("FAIL zw_after%0d: resp=%b ready=%b, need 0 1", k, resp_valid0, ready0);
      end
    end
  endtask

  task automatic test_out_of_range;
    int lat; logic [15:0] rd; logic er;
    run_req(1'b0, 16'd1023, 16'h7777, lat, rd, er);
    run_req(1'b0, 16'd1024, 16'hFFFF, lat, rd, er);
    checks++;
    if (lat !== 3 || rd !== 16'h0000 || er !== 1'b1) begin
      errors++;
      $display("FAIL oor_wr: lat=%0d rdata=%h err=%b, need 3 0000 1", lat, rd, er);
    end
    run_req(1'b1, 16'd1024, 16'h0000, lat, rd, er);
    checks++;
    if (lat !== 3 || rd !== 16'h0000 || er !== 1'b1) begin
      errors++;
      $display("FAIL oor_rd: lat=%0d rdata=%h err=%b, need 3 0000 1", lat, rd, er);
    end
    dbg_addr = 16'd1023;
    #1;
    checks++;
    if (dbg2 !== 16'h7777) begin
      errors++;
      $display("FAIL oor_dbg1023: dbg=%h, need 7777", dbg2);
    end
    dbg_addr = 16'd1024;
    #1;
    checks++;
    if (dbg2 !== 16'h0000) begin
      errors++;
      $display("FAIL oor_dbg1024: dbg=%h, need 0000", dbg2);
    end
    run_req(1'b1, 16'd1023, 16'h0000, lat, rd, er);
    checks++;
    if (lat !== 3 || rd !== 16'h7777 || er !== 1'b0) begin
      errors++;
      $display("FAIL rd1023: lat=%0d rdata=%h err=%b, need 3 7777 0", lat, rd, er);
    end
  endtask

  task automatic test_busy_ignore;
    int lat; logic [15:0] rd; logic er;
    int pulses;
    run_req(1'b0, 16'd61, 16'h0000, lat, rd, er);
    run_req(1'b0, 16'd62, 16'h0000, lat, rd, er);
    @(negedge clk);
    we_n = 1'b0; addr = 16'd50; wdata = 16'h0A0A; rv2 = 1'b1;
    @(posedge clk);
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (resp_valid2) pulses++;
      if (i < 3) begin
        addr = 16'd60 + 16'(i); wdata = 16'hBEEF;
        checks++;
        if (ready2 !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready%0d: ready=%b, need 0", i, ready2);
        end
      end else begin
        rv2 = 1'b0;
      end
      if (i == 3) begin
        checks++;
        if (resp_valid2 !== 1'b1 || rdata2 !== 16'h0A0A) begin
          errors++;
          $display("FAIL busy_resp: resp=%b rdata=%h, need 1 0a0a", resp_valid2, rdata2);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL busy_pulses: got %0d, need 1", pulses);
    end
    dbg_addr = 16'd61;
    #1;
    checks++;
    if (dbg2 !== 16'h0000) begin
      errors++;
      $display("FAIL busy_dbg61: dbg=%h, need 0000", dbg2);
    end
    dbg_addr = 16'd62;
    #1;
    checks++;
    if (dbg2 !== 16'h0000) begin
      errors++;
      $display("FAIL busy_dbg62: dbg=%h, need 0000", dbg2);
    end
    dbg_addr = 16'd50;
    #1;
    checks++;
    if (dbg2 !== 16'h0A0A) begin
      errors++;
      $display("FAIL busy_dbg50: dbg=%h, need 0a0a", dbg2);
    end
  endtask

  task automatic test_reset_mid_write;
    int lat; logic [15:0] rd; logic er;
    int pulses;
    run_req(1'b0, 16'd300, 16'h0000, lat, rd, er);
    @(negedge clk);
    we_n = 1'b0; addr = 16'd300; wdata = 16'h5555; rv2 = 1'b1;
    @(posedge clk);
    #1 rv2 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready2 !== 1'b1 || resp_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ready: ready=%b resp=%b, need 1 0", ready2, resp_valid2);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid2) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rst_mid_pulses: got %0d, need 0", pulses);
    end
    dbg_addr = 16'd300;
    #1;
    checks++;
    if (dbg2 !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_mem300: dbg=%h, need 0000", dbg2);
    end
  endtask

  task automatic test_debug_peek;
    int lat; logic [15:0] rd; logic er;
    run_req(1'b0, 16'd300, 16'd87, lat, rd, er);
    @(negedge clk);
    dbg_addr = 16'd300;
    #1;
    checks++;
    if (dbg2 !== 16'd87 || ready2 !== 1'b1) begin
      errors++;
      $display("FAIL dbg_peek: dbg=%0d ready=%b, need 87 1", dbg2, ready2);
    end
    dbg_addr = 16'd100;
    #1;
    checks++;
    if (dbg2 !== 16'h00AB) begin
      errors++;
      $display("FAIL dbg_peek100: dbg=%h, need 00ab", dbg2);
    end
    dbg_addr = 16'd5;
    #1;
    checks++;
    if (dbg0 !== 16'h1234) begin
      errors++;
      $display("FAIL dbg_peek_w0: dbg=%h, need 1234", dbg0);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_zero_wait;
    test_out_of_range;
    test_busy_ignore;
    test_reset_mid_write;
    test_debug_peek;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, need completion");
    $fatal(1);
  end

endmodule
